// File: rtl/match_round_controller.sv
// Multi-round match sequencer for the button-press counter game.
// It drives the counter block's activator, tallies round wins, and declares a champion or a draw.
module match_round_controller #(
    parameter int unsigned NUM_PLAYERS    = 3,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned WIN_ROUNDS     = 3,
    parameter int unsigned MAX_ROUNDS     = 9,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned SHOW_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           result_valid,
    input  logic                           result_tie,
    input  logic [1:0]                     result_idx,
    output logic                           activator,
    output logic                           busy,
    output logic [3:0]                     round_num,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           match_done,
    output logic                           champion_valid,
    output logic [1:0]                     champion,
    output logic                           timeout_err
);

    localparam int unsigned PHASE_MAX = (GAP_CYCLES > SHOW_CYCLES) ? GAP_CYCLES : SHOW_CYCLES;
    localparam int unsigned CNT_LIM   = (TIMEOUT_CYCLES > PHASE_MAX) ? TIMEOUT_CYCLES : PHASE_MAX;
    localparam int unsigned CNT_W     = $clog2(CNT_LIM);

    localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SHOW_LAST   = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE   = SCORE_W'(WIN_ROUNDS);
    localparam logic [3:0]         ROUND_LIMIT = 4'(MAX_ROUNDS);
    localparam logic [2:0]         NP          = 3'(NUM_PLAYERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PLAY,
        S_SHOW,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         round_q, round_d;
    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
    logic [1:0]         champ_q, champ_d;
    logic               champ_v_q, champ_v_d;
    logic               timeout_q, timeout_d;
    logic               activator_q, activator_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               win_hit;
    logic               decisive;
    logic [SCORE_W-1:0] max_score;
    logic [1:0]         max_idx;
    logic [2:0]         max_cnt;

    // Champion scan: a champion exists only if exactly one player holds the top score.
    always_comb begin
        win_hit   = 1'b0;
        max_score = '0;
        max_idx   = '0;
        max_cnt   = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (score_q[p] == WIN_SCORE) begin
                win_hit = 1'b1;
            end
            if (p == 0 || score_q[p] > max_score) begin
                max_score = score_q[p];
                max_idx   = 2'(p);
                max_cnt   = 3'd1;
            end else if (score_q[p] == max_score) begin
                max_cnt = max_cnt + 3'd1;
            end
        end
    end

    assign decisive = !result_tie && ({1'b0, result_idx} < NP);

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        score_d   = score_q;
        champ_d   = champ_q;
        champ_v_d = champ_v_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_ARM;
                    round_d   = '0;
                    score_d   = '{default: '0};
                    champ_d   = '0;
                    champ_v_d = 1'b0;
                end
            end
            S_ARM: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (result_valid) begin
                    state_d = S_SHOW;
                    round_d = round_q + 4'd1;
                    if (decisive) begin
                        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                            if (result_idx == 2'(p)) begin
                                score_d[p] = score_q[p] + SCORE_W'(1);
                            end
                        end
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_ARM;
                    timeout_d = 1'b1;
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    if (win_hit || round_q == ROUND_LIMIT) begin
                        state_d   = S_DONE;
                        champ_v_d = (max_cnt == 3'd1);
                        champ_d   = (max_cnt == 3'd1) ? max_idx : 2'd0;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            round_d   = '0;
            score_d   = '{default: '0};
            champ_d   = '0;
            champ_v_d = 1'b0;
            timeout_d = 1'b0;
        end

        // Every state entry restarts the shared counter, including PLAY -> ARM on a timeout.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_ARM || state_q == S_PLAY || state_q == S_SHOW) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        activator_d = (state_d == S_PLAY) || (state_d == S_SHOW);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            round_q     <= '0;
            score_q     <= '{default: '0};
            champ_q     <= '0;
            champ_v_q   <= 1'b0;
            timeout_q   <= 1'b0;
            activator_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            round_q     <= round_d;
            score_q     <= score_d;
            champ_q     <= champ_d;
            champ_v_q   <= champ_v_d;
            timeout_q   <= timeout_d;
            activator_q <= activator_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        score = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            score[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

    assign activator      = activator_q;
    assign busy           = busy_q;
    assign round_num      = round_q;
    assign match_done     = done_q;
    assign champion_valid = champ_v_q;
    assign champion       = champ_q;
    assign timeout_err    = timeout_q;

endmodule
